// File: rtl/int_pkg.sv
// int_pkg: shared state encoding and default sizing for the interrupt controller
package int_pkg;
   localparam int N_SRC = 4;
   localparam int VEC_W = 10;
   localparam logic [VEC_W-1:0] VEC_BASE = 10'h3C0;
   localparam int VEC_STRIDE = 4;
   localparam int ID_W = $clog2(N_SRC);
   typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;
endpackage

// File: rtl/prio_enc.sv
// prio_enc: lowest-index-wins priority encoder over a request vector
module prio_enc #(
   parameter int N = 4,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   output logic          valid,
   output logic [IW-1:0] id
);
   always_comb begin
      id = '0;
      for (int i = N - 1; i >= 0; i--)
         if (req[i]) id = IW'(i);
   end
   assign valid = |req;
endmodule

// File: rtl/int_controller.sv
// int_controller: latches event pulses, masks and arbitrates them, and runs the irq/ack/eoi handshake
module int_controller #(
   parameter int N_SRC = int_pkg::N_SRC,
   parameter int VEC_W = int_pkg::VEC_W,
   parameter logic [VEC_W-1:0] VEC_BASE = int_pkg::VEC_BASE,
   parameter int VEC_STRIDE = int_pkg::VEC_STRIDE,
   parameter int IW = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_SRC-1:0] src,
   input  logic             mask_we,
   input  logic [N_SRC-1:0] mask_wdata,
   input  logic             ack,
   input  logic             eoi,
   output logic             irq,
   output logic [VEC_W-1:0] vector,
   output logic [IW-1:0]    active_id,
   output logic [N_SRC-1:0] pending,
   output logic [N_SRC-1:0] mask
);
   import int_pkg::*;
   state_t state;
   logic [N_SRC-1:0] new_mask, clr;
   logic win_valid, do_ack;
   logic [IW-1:0] win_id;
   logic [VEC_W-1:0] vec_next;
   prio_enc #(.N(N_SRC), .IW(IW)) u_enc (
      .req   (pending & mask),
      .valid (win_valid),
      .id    (win_id)
   );
   assign new_mask = mask_we ? mask_wdata : mask;
   assign do_ack = (state == REQ) && ack;
   assign clr = do_ack ? (N_SRC'(1) << active_id) : '0;
   assign vec_next = VEC_BASE + VEC_W'(VEC_STRIDE) * VEC_W'(win_id);
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         pending <= '0;
         mask <= '0;
         irq <= 1'b0;
         vector <= '0;
         active_id <= '0;
      end else begin
         // a new event in the clearing cycle survives the ack
         pending <= (pending & ~clr) | src;
         if (mask_we) mask <= mask_wdata;
         case (state)
            IDLE: if (win_valid) begin
               active_id <= win_id;
               vector <= vec_next;
               irq <= 1'b1;
               state <= REQ;
            end
            REQ: if (ack) begin
               irq <= 1'b0;
               state <= SERVICE;
            end else if (!new_mask[active_id]) begin
               irq <= 1'b0;
               state <= IDLE;
            end
            SERVICE: if (eoi) state <= IDLE;
            default: begin
               irq <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end
endmodule
